// File: rtl/csr_access_ctrl.sv
// csr_access_ctrl: multi-cycle sequencer that owns the M-mode CSR file's
// single read port and dual write ports. It serialises Zicsr read-modify-write
// ops, ecall trap entry (mepc/mcause update, jump to mtvec) and mret (jump to mepc).
module csr_access_ctrl #(
    parameter int unsigned     XLEN         = 32,
    parameter logic [XLEN-1:0] MCAUSE_ECALL = 32'd11
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      req_op,
    input  logic [11:0]     req_csr_addr,
    input  logic [XLEN-1:0] req_wdata,
    input  logic            req_nowr,
    input  logic [XLEN-1:0] req_pc,
    output logic            rsp_valid,
    output logic [XLEN-1:0] rsp_rdata,
    output logic            rsp_illegal,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    output logic            csr_wen,
    output logic [11:0]     csr_waddr1,
    output logic [XLEN-1:0] csr_wdata1,
    output logic [11:0]     csr_waddr2,
    output logic [XLEN-1:0] csr_wdata2,
    output logic [11:0]     csr_raddr,
    input  logic [XLEN-1:0] csr_rdata
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    localparam logic [2:0]  OP_CSRRW    = 3'b000;
    localparam logic [2:0]  OP_CSRRS    = 3'b001;
    localparam logic [2:0]  OP_CSRRC    = 3'b010;
    localparam logic [2:0]  OP_ECALL    = 3'b100;
    localparam logic [2:0]  OP_MRET     = 3'b101;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;

    state_t          state, state_n;
    logic [2:0]      op_q;
    logic [11:0]     addr_q;
    logic [XLEN-1:0] wdata_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] old_q;
    logic            nowr_q;
    logic            illegal_q;
    logic            accept;
    logic            addr_legal;
    logic            req_legal;
    logic            csr_op_q;
    logic            trap_op_q;
    logic [XLEN-1:0] new_val;

    assign accept    = req_valid && (state == IDLE);
    assign csr_op_q  = (op_q == OP_CSRRW) || (op_q == OP_CSRRS) || (op_q == OP_CSRRC);
    assign trap_op_q = (op_q == OP_ECALL) || (op_q == OP_MRET);

    // Classify the incoming request: reserved ops and unknown CSRs are illegal.
    always_comb begin
        addr_legal = (req_csr_addr == CSR_MSTATUS) || (req_csr_addr == CSR_MTVEC) ||
                     (req_csr_addr == CSR_MEPC)    || (req_csr_addr == CSR_MCAUSE);
        case (req_op)
            OP_CSRRW, OP_CSRRS, OP_CSRRC: req_legal = addr_legal;
            OP_ECALL, OP_MRET:            req_legal = 1'b1;
            default:                      req_legal = 1'b0;
        endcase
    end

    // Read-modify-write result for the Zicsr ops.
    always_comb begin
        case (op_q)
            OP_CSRRS: new_val = old_q | wdata_q;
            OP_CSRRC: new_val = old_q & ~wdata_q;
            default:  new_val = wdata_q;
        endcase
    end

    // State register, request latches and captured old CSR value.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            op_q      <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            pc_q      <= '0;
            nowr_q    <= 1'b0;
            illegal_q <= 1'b0;
            old_q     <= '0;
        end else begin
            state <= state_n;
            if (accept) begin
                op_q      <= req_op;
                addr_q    <= req_csr_addr;
                wdata_q   <= req_wdata;
                pc_q      <= req_pc;
                nowr_q    <= req_nowr;
                illegal_q <= !req_legal;
                // cleared so an illegal request (which skips READ) reports zero
                old_q     <= '0;
            end else if (state == READ) begin
                old_q <= csr_rdata;
            end
        end
    end

    // Next-state logic and all outputs, decoded from the current state.
    always_comb begin
        state_n        = state;
        req_ready      = 1'b0;
        rsp_valid      = 1'b0;
        rsp_rdata      = '0;
        rsp_illegal    = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        csr_wen        = 1'b0;
        csr_raddr      = CSR_MSTATUS;
        csr_waddr1     = CSR_MSTATUS;
        csr_wdata1     = '0;
        csr_waddr2     = CSR_MSTATUS;
        csr_wdata2     = '0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_n = req_legal ? READ : DONE;
            end
            READ: begin
                case (op_q)
                    OP_ECALL: csr_raddr = CSR_MTVEC;
                    OP_MRET:  csr_raddr = CSR_MEPC;
                    default:  csr_raddr = addr_q;
                endcase
                state_n = (op_q == OP_MRET) ? DONE : WRITE;
            end
            WRITE: begin
                state_n = DONE;
                if (op_q == OP_ECALL) begin
                    csr_wen    = 1'b1;
                    csr_waddr1 = CSR_MEPC;
                    csr_wdata1 = pc_q;
                    csr_waddr2 = CSR_MCAUSE;
                    csr_wdata2 = MCAUSE_ECALL;
                end else begin
                    csr_wen    = (op_q == OP_CSRRW) || !nowr_q;
                    csr_waddr1 = addr_q;
                    csr_wdata1 = new_val;
                    csr_waddr2 = addr_q;
                    csr_wdata2 = new_val;
                end
            end
            DONE: begin
                state_n     = IDLE;
                rsp_valid   = 1'b1;
                rsp_illegal = illegal_q;
                if (!illegal_q && csr_op_q) rsp_rdata = old_q;
                if (!illegal_q && trap_op_q) begin
                    redirect_valid = 1'b1;
                    redirect_pc    = {old_q[XLEN-1:2], 2'b00};
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_csr_access_ctrl.sv
// Testbench for csr_access_ctrl: a simple CSR file behind the DUT, directed
// scenarios with spec-derived constants, and a randomized run checked against
// a transaction-level reference model.
module tb_csr_access_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [11:0] req_csr_addr;
    logic [31:0] req_wdata;
    logic        req_nowr;
    logic [31:0] req_pc;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_illegal;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        csr_wen;
    logic [11:0] csr_waddr1;
    logic [31:0] csr_wdata1;
    logic [11:0] csr_waddr2;
    logic [31:0] csr_wdata2;
    logic [11:0] csr_raddr;
    logic [31:0] csr_rdata;

    int n_pass  = 0;
    int n_total = 0;

    csr_access_ctrl #(.XLEN(32), .MCAUSE_ECALL(32'd11)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_csr_addr(req_csr_addr), .req_wdata(req_wdata), .req_nowr(req_nowr),
        .req_pc(req_pc),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_illegal(rsp_illegal),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .csr_wen(csr_wen), .csr_waddr1(csr_waddr1), .csr_wdata1(csr_wdata1),
        .csr_waddr2(csr_waddr2), .csr_wdata2(csr_wdata2),
        .csr_raddr(csr_raddr), .csr_rdata(csr_rdata)
    );

    always #5 clk = ~clk;

    // ---------------- CSR file (environment, not the reference) ----------------
    logic [31:0] file_csr [4];
    logic        load_file;

    function automatic int csr_idx(input logic [11:0] a);
        case (a)
            12'h300: return 0;
            12'h305: return 1;
            12'h341: return 2;
            12'h342: return 3;
            default: return -1;
        endcase
    endfunction

    always_comb begin
        case (csr_raddr)
            12'h300: csr_rdata = file_csr[0];
            12'h305: csr_rdata = file_csr[1];
            12'h341: csr_rdata = file_csr[2];
            12'h342: csr_rdata = file_csr[3];
            default: csr_rdata = 32'hDEAD_BEEF;
        endcase
    end

    always @(posedge clk) begin : file_wr
        int i1;
        int i2;
        if (load_file) begin
            file_csr[0] <= 32'h0000_1800;
            file_csr[1] <= 32'h0000_0000;
            file_csr[2] <= 32'h8000_0044;
            file_csr[3] <= 32'h0000_0000;
        end else if (csr_wen) begin
            i1 = csr_idx(csr_waddr1);
            i2 = csr_idx(csr_waddr2);
            if (i1 >= 0) file_csr[i1] <= csr_wdata1;
            if (i2 >= 0) file_csr[i2] <= csr_wdata2;
        end
    end

    // ---------------- reference model (transaction level) ----------------
    logic [31:0] ref_csr [4];

    typedef struct {
        int          lat;
        logic [31:0] rdata;
        logic        illegal;
        logic        redir;
        logic [31:0] redir_pc;
        logic        wen;
        logic [11:0] wa1;
        logic [31:0] wd1;
        logic [11:0] wa2;
        logic [31:0] wd2;
    } exp_t;

    function automatic exp_t model(input logic [2:0] op, input logic [11:0] addr,
                                   input logic [31:0] wd, input logic nw,
                                   input logic [31:0] pc);
        exp_t        e;
        int          i;
        logic [31:0] old;
        logic [31:0] nv;
        e = '{default: 0};
        i = csr_idx(addr);
        if (op == 3'd3 || op > 3'd5 || (op <= 3'd2 && i < 0)) begin
            e.lat = 1;
            e.illegal = 1'b1;
            return e;
        end
        if (op <= 3'd2) begin
            old = ref_csr[i];
            if (op == 3'd0)      nv = wd;
            else if (op == 3'd1) nv = old | wd;
            else                 nv = old & ~wd;
            e.lat = 3;
            e.rdata = old;
            e.wen = (op == 3'd0) || !nw;
            e.wa1 = addr; e.wd1 = nv; e.wa2 = addr; e.wd2 = nv;
            if (e.wen) ref_csr[i] = nv;
        end else if (op == 3'd4) begin
            e.lat = 3;
            e.redir = 1'b1;
            e.redir_pc = ref_csr[1] & ~32'h3;
            e.wen = 1'b1;
            e.wa1 = 12'h341; e.wd1 = pc; e.wa2 = 12'h342; e.wd2 = 32'd11;
            ref_csr[2] = pc;
            ref_csr[3] = 32'd11;
        end else begin
            e.lat = 2;
            e.redir = 1'b1;
            e.redir_pc = ref_csr[2] & ~32'h3;
        end
        return e;
    endfunction

    // ---------------- transaction driver / observer ----------------
    typedef struct {
        logic        accepted;
        int          rsp_cyc;
        int          rsp_cnt;
        logic [31:0] rdata;
        logic        illegal;
        int          redir_cnt;
        logic [31:0] redir_pc;
        int          wen_cnt;
        int          wen_cyc;
        logic [11:0] wa1;
        logic [31:0] wd1;
        logic [11:0] wa2;
        logic [31:0] wd2;
        logic        ready_ok;
    } obs_t;

    task automatic run_req(input logic [2:0] op, input logic [11:0] addr,
                           input logic [31:0] wd, input logic nw,
                           input logic [31:0] pc, output obs_t o);
        int  waited = 0;
        logic exp_ready;
        o = '{default: 0};
        @(negedge clk);
        req_valid = 1'b1; req_op = op; req_csr_addr = addr;
        req_wdata = wd; req_nowr = nw; req_pc = pc;
        while (!req_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        o.accepted = req_ready;
        if (!o.accepted) begin
            req_valid = 1'b0;
            return;
        end
        o.ready_ok = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            req_valid = 1'b0;
            if (rsp_valid) begin
                if (o.rsp_cnt == 0) begin
                    o.rsp_cyc  = k;
                    o.rdata    = rsp_rdata;
                    o.illegal  = rsp_illegal;
                    o.redir_pc = redirect_pc;
                end
                o.rsp_cnt++;
            end
            if (redirect_valid) o.redir_cnt++;
            if (csr_wen) begin
                o.wen_cnt++;
                o.wen_cyc = k;
                o.wa1 = csr_waddr1; o.wd1 = csr_wdata1;
                o.wa2 = csr_waddr2; o.wd2 = csr_wdata2;
            end
            exp_ready = (o.rsp_cnt > 0) && (k > o.rsp_cyc);
            if (req_ready !== exp_ready) o.ready_ok = 1'b0;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b0; load_file = 1'b1; req_valid = 1'b0; req_op = '0;
        req_csr_addr = '0; req_wdata = '0; req_nowr = 1'b0; req_pc = '0;
        for (int i = 0; i < 4; i++) ref_csr[i] = 32'h0;
        ref_csr[0] = 32'h0000_1800;
        ref_csr[2] = 32'h8000_0044;
        repeat (3) @(posedge clk);
        @(negedge clk);
        load_file = 1'b0; rst = 1'b1;
        @(negedge clk);
        n_total++; if (req_ready !== 1'b1) $display("FAIL reset_ready got %b exp 1", req_ready); else n_pass++;
        n_total++; if ({rsp_valid, rsp_illegal, redirect_valid, csr_wen} !== 4'b0)
            $display("FAIL reset_pulses got %b exp 0000", {rsp_valid, rsp_illegal, redirect_valid, csr_wen}); else n_pass++;
        n_total++; if ({csr_raddr, csr_waddr1, csr_waddr2} !== {12'h300, 12'h300, 12'h300})
            $display("FAIL reset_addrs got %h %h %h exp 300 300 300", csr_raddr, csr_waddr1, csr_waddr2); else n_pass++;
        n_total++; if ({csr_wdata1, csr_wdata2, rsp_rdata} !== 96'h0)
            $display("FAIL reset_data got %h %h %h exp 0", csr_wdata1, csr_wdata2, rsp_rdata); else n_pass++;
    endtask

    task automatic test_csrrw();
        obs_t o;
        exp_t e;
        e = model(3'd0, 12'h305, 32'h8000_0100, 1'b1, 32'h0);
        run_req(3'd0, 12'h305, 32'h8000_0100, 1'b1, 32'h0, o);
        n_total++; if (o.accepted !== 1'b1) $display("FAIL csrrw_accept got %b exp 1", o.accepted); else n_pass++;
        n_total++; if (o.wen_cnt !== 1 || o.wen_cyc !== 2)
            $display("FAIL csrrw_wen got cnt=%0d cyc=%0d exp cnt=1 cyc=2", o.wen_cnt, o.wen_cyc); else n_pass++;
        n_total++; if ({o.wa1, o.wd1, o.wa2, o.wd2} !== {12'h305, 32'h8000_0100, 12'h305, 32'h8000_0100})
            $display("FAIL csrrw_ports got %h=%h %h=%h exp 305=80000100 twice", o.wa1, o.wd1, o.wa2, o.wd2); else n_pass++;
        n_total++; if (o.rsp_cyc !== 3 || o.rsp_cnt !== 1)
            $display("FAIL csrrw_rsp got cyc=%0d cnt=%0d exp 3/1", o.rsp_cyc, o.rsp_cnt); else n_pass++;
        n_total++; if (o.rdata !== 32'h0 || o.redir_cnt !== 0 || o.illegal !== 1'b0)
            $display("FAIL csrrw_result got rdata=%h redir=%0d ill=%b exp 0/0/0", o.rdata, o.redir_cnt, o.illegal); else n_pass++;
        n_total++; if (o.ready_ok !== 1'b1) $display("FAIL csrrw_ready got %b exp 1", o.ready_ok); else n_pass++;
    endtask

    task automatic test_csrrs();
        obs_t o;
        exp_t e;
        e = model(3'd1, 12'h300, 32'h8, 1'b0, 32'h0);
        run_req(3'd1, 12'h300, 32'h8, 1'b0, 32'h0, o);
        n_total++; if (o.wen_cnt !== 1 || o.wd1 !== 32'h1808 || o.wd2 !== 32'h1808 || o.wa1 !== 12'h300)
            $display("FAIL csrrs_write got cnt=%0d %h=%h/%h exp 1 300=1808", o.wen_cnt, o.wa1, o.wd1, o.wd2); else n_pass++;
        n_total++; if (o.rdata !== 32'h1800 || o.rsp_cyc !== 3)
            $display("FAIL csrrs_rdata got %h@%0d exp 1800@3", o.rdata, o.rsp_cyc); else n_pass++;
        e = model(3'd1, 12'h300, 32'h8, 1'b1, 32'h0);
        run_req(3'd1, 12'h300, 32'h8, 1'b1, 32'h0, o);
        n_total++; if (o.wen_cnt !== 0) $display("FAIL csrrs_nowr_wen got %0d exp 0", o.wen_cnt); else n_pass++;
        n_total++; if (o.rdata !== 32'h1808 || o.rsp_cyc !== 3)
            $display("FAIL csrrs_nowr_rdata got %h@%0d exp 1808@3", o.rdata, o.rsp_cyc); else n_pass++;
    endtask

    task automatic test_mret();
        obs_t o;
        exp_t e;
        e = model(3'd0, 12'h305, 32'h8000_0103, 1'b0, 32'h0);
        run_req(3'd0, 12'h305, 32'h8000_0103, 1'b0, 32'h0, o);
        e = model(3'd5, 12'h000, 32'h0, 1'b0, 32'h0);
        run_req(3'd5, 12'h000, 32'h0, 1'b0, 32'h0, o);
        n_total++; if (o.rsp_cyc !== 2 || o.redir_cnt !== 1)
            $display("FAIL mret_timing got rsp@%0d redir=%0d exp 2/1", o.rsp_cyc, o.redir_cnt); else n_pass++;
        n_total++; if (o.redir_pc !== 32'h8000_0044) $display("FAIL mret_pc got %h exp 80000044", o.redir_pc); else n_pass++;
        n_total++; if (o.wen_cnt !== 0 || o.rdata !== 32'h0)
            $display("FAIL mret_side got wen=%0d rdata=%h exp 0/0", o.wen_cnt, o.rdata); else n_pass++;
    endtask

    task automatic test_ecall();
        obs_t o;
        exp_t e;
        e = model(3'd4, 12'h123, 32'h0, 1'b0, 32'h8000_0040);
        run_req(3'd4, 12'h123, 32'h0, 1'b0, 32'h8000_0040, o);
        n_total++; if (o.wen_cnt !== 1 || o.wen_cyc !== 2)
            $display("FAIL ecall_wen got cnt=%0d cyc=%0d exp 1/2", o.wen_cnt, o.wen_cyc); else n_pass++;
        n_total++; if ({o.wa1, o.wd1, o.wa2, o.wd2} !== {12'h341, 32'h8000_0040, 12'h342, 32'd11})
            $display("FAIL ecall_ports got %h=%h %h=%h exp 341=80000040 342=b", o.wa1, o.wd1, o.wa2, o.wd2); else n_pass++;
        n_total++; if (o.rsp_cyc !== 3 || o.redir_cnt !== 1 || o.redir_pc !== 32'h8000_0100)
            $display("FAIL ecall_redirect got @%0d n=%0d pc=%h exp 3/1/80000100", o.rsp_cyc, o.redir_cnt, o.redir_pc); else n_pass++;
        n_total++; if (o.rdata !== 32'h0) $display("FAIL ecall_rdata got %h exp 0", o.rdata); else n_pass++;
    endtask

    task automatic test_illegal();
        obs_t o;
        exp_t e;
        logic [2:0] ops [2];
        logic [11:0] addrs [2];
        ops[0] = 3'd0; addrs[0] = 12'h7C0;
        ops[1] = 3'd3; addrs[1] = 12'h300;
        for (int i = 0; i < 2; i++) begin
            e = model(ops[i], addrs[i], 32'hFFFF_FFFF, 1'b0, 32'h0);
            run_req(ops[i], addrs[i], 32'hFFFF_FFFF, 1'b0, 32'h0, o);
            n_total++; if (o.rsp_cyc !== 1 || o.illegal !== 1'b1)
                $display("FAIL illegal_rsp[%0d] got @%0d ill=%b exp @1 ill=1", i, o.rsp_cyc, o.illegal); else n_pass++;
            n_total++; if (o.rdata !== 32'h0 || o.wen_cnt !== 0 || o.redir_cnt !== 0)
                $display("FAIL illegal_side[%0d] got rdata=%h wen=%0d redir=%0d exp 0", i, o.rdata, o.wen_cnt, o.redir_cnt); else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        exp_t e1, e2;
        logic [31:0] a, b;
        logic        busy_ready;
        logic        r4, r5;
        logic [31:0] rd [8];
        logic        rv [8];
        int          rsp_n = 0;
        a = $urandom; b = $urandom;
        e1 = model(3'd0, 12'h342, a, 1'b0, 32'h0);
        e2 = model(3'd0, 12'h342, b, 1'b0, 32'h0);
        @(negedge clk);
        req_valid = 1'b1; req_op = 3'd0; req_csr_addr = 12'h342; req_wdata = a; req_nowr = 1'b0;
        busy_ready = 1'b0; r4 = 1'b0; r5 = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            req_wdata = b;
            if (k == 5) req_valid = 1'b0;
            rv[k] = rsp_valid; rd[k] = rsp_rdata;
            if (rsp_valid) rsp_n++;
            if (k <= 3 && req_ready) busy_ready = 1'b1;
            if (k == 4) r4 = req_ready;
            if (k == 5) r5 = req_ready;
        end
        n_total++; if (busy_ready !== 1'b0) $display("FAIL b2b_busy_ready got 1 exp 0"); else n_pass++;
        n_total++; if (r4 !== 1'b1 || r5 !== 1'b0) $display("FAIL b2b_idle_slot got %b%b exp 10", r4, r5); else n_pass++;
        n_total++; if (rv[3] !== 1'b1 || rd[3] !== e1.rdata)
            $display("FAIL b2b_first got v=%b rdata=%h exp 1 %h", rv[3], rd[3], e1.rdata); else n_pass++;
        n_total++; if (rv[7] !== 1'b1 || rd[7] !== e2.rdata || rsp_n !== 2)
            $display("FAIL b2b_second got v=%b rdata=%h n=%0d exp 1 %h 2", rv[7], rd[7], rsp_n, e2.rdata); else n_pass++;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_midop();
        exp_t e;
        logic wen_in_write;
        logic bad_after;
        logic ready_after;
        e = model(3'd4, 12'h0, 32'h0, 1'b0, 32'h8000_0200);
        @(negedge clk);
        req_valid = 1'b1; req_op = 3'd4; req_pc = 32'h8000_0200;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        wen_in_write = csr_wen;
        rst = 1'b0;
        @(negedge clk);
        n_total++; if (wen_in_write !== 1'b1) $display("FAIL rstmid_in_write got wen=%b exp 1", wen_in_write); else n_pass++;
        n_total++; if ({csr_wen, rsp_valid, redirect_valid} !== 3'b000)
            $display("FAIL rstmid_after got wen/rsp/redir=%b exp 000", {csr_wen, rsp_valid, redirect_valid}); else n_pass++;
        @(negedge clk);
        rst = 1'b1;
        bad_after = 1'b0; ready_after = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (csr_wen || rsp_valid || redirect_valid || rsp_illegal) bad_after = 1'b1;
            if (!req_ready) ready_after = 1'b0;
        end
        n_total++; if (bad_after !== 1'b0) $display("FAIL rstmid_quiet got pulse exp none"); else n_pass++;
        n_total++; if (ready_after !== 1'b1) $display("FAIL rstmid_ready got 0 exp 1"); else n_pass++;
    endtask

    task automatic test_random();
        obs_t o;
        exp_t e;
        logic [2:0]  op_tab [11];
        logic [11:0] addr_tab [4];
        logic [2:0]  op;
        logic [11:0] addr;
        logic [31:0] wd, pc;
        logic        nw;
        op_tab = '{3'd0, 3'd1, 3'd2, 3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd7};
        addr_tab = '{12'h300, 12'h305, 12'h341, 12'h342};
        for (int n = 0; n < 60; n++) begin
            op = op_tab[$urandom_range(0, 10)];
            addr = ($urandom_range(0, 4) == 0) ? 12'($urandom) : addr_tab[$urandom_range(0, 3)];
            wd = $urandom; pc = $urandom; nw = 1'($urandom);
            e = model(op, addr, wd, nw, pc);
            run_req(op, addr, wd, nw, pc, o);
            n_total++; if (o.accepted !== 1'b1 || o.rsp_cnt !== 1 || o.rsp_cyc !== e.lat)
                $display("FAIL rnd%0d_timing op=%0d got acc=%b n=%0d @%0d exp 1/1/@%0d", n, op, o.accepted, o.rsp_cnt, o.rsp_cyc, e.lat); else n_pass++;
            n_total++; if (o.rdata !== e.rdata || o.illegal !== e.illegal)
                $display("FAIL rnd%0d_rsp op=%0d a=%h got %h ill=%b exp %h ill=%b", n, op, addr, o.rdata, o.illegal, e.rdata, e.illegal); else n_pass++;
            n_total++; if (o.redir_cnt !== int'(e.redir) || (e.redir && o.redir_pc !== e.redir_pc))
                $display("FAIL rnd%0d_redir op=%0d got n=%0d pc=%h exp n=%0d pc=%h", n, op, o.redir_cnt, o.redir_pc, e.redir, e.redir_pc); else n_pass++;
            n_total++; if (o.wen_cnt !== int'(e.wen))
                $display("FAIL rnd%0d_wen op=%0d nw=%b got %0d exp %0d", n, op, nw, o.wen_cnt, e.wen); else n_pass++;
            if (e.wen) begin
                n_total++; if (o.wen_cyc !== 2 || {o.wa1, o.wd1, o.wa2, o.wd2} !== {e.wa1, e.wd1, e.wa2, e.wd2})
                    $display("FAIL rnd%0d_wport got @%0d %h=%h %h=%h exp @2 %h=%h %h=%h", n, o.wen_cyc, o.wa1, o.wd1, o.wa2, o.wd2, e.wa1, e.wd1, e.wa2, e.wd2); else n_pass++;
            end
            n_total++; if (o.ready_ok !== 1'b1) $display("FAIL rnd%0d_ready got 0 exp 1", n); else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_csrrw();
        test_csrrs();
        test_mret();
        test_ecall();
        test_illegal();
        test_back_to_back();
        test_reset_midop();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired after %0d/%0d checks", n_pass, n_total);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/csr_access_ctrl.md
Name: csr_access_ctrl

Overview:
- Multi-cycle sequencer in front of the machine-mode CSR register file (mstatus 0x300, mtvec 0x305, mepc 0x341, mcause 0x342).
- Owns the file's single read port and dual write ports. Serialises Zicsr read-modify-write ops, ecall trap entry (mepc/mcause update, jump to mtvec) and mret (jump to mepc).
- Sits between the decode/execute stage and the CSR file. Core stalls while req_ready is low.

Parameters:
- MCAUSE_ECALL, 32'd11, value written to mcause on ecall.
- XLEN, 32, data/pc width (only 32 supported).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-low (0 = reset)
- req_valid  in  1  request present
- req_ready  out  1  controller idle, request accepted when valid & ready
- req_op  in  3  000 CSRRW, 001 CSRRS, 010 CSRRC, 100 ECALL, 101 MRET, others reserved
- req_csr_addr  in  12  CSR address (ignored for ECALL/MRET)
- req_wdata  in  32  rs1/zimm operand
- req_nowr  in  1  suppress CSR write (rs1 = x0 for CSRRS/CSRRC)
- req_pc  in  32  pc of the requesting instruction
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  32  old CSR value (rd writeback), 0 for ECALL/MRET/illegal
- rsp_illegal  out  1  qualifies rsp_valid: unknown CSR or reserved op
- redirect_valid  out  1  one-cycle pc redirect pulse, coincident with rsp_valid
- redirect_pc  out  32  redirect target
- csr_wen  out  1  CSR file write enable
- csr_waddr1 / csr_wdata1  out  12 / 32  write port 1
- csr_waddr2 / csr_wdata2  out  12 / 32  write port 2
- csr_raddr  out  12  CSR file read address
- csr_rdata  in  32  CSR file read data (combinational)

Behaviour:
- FSM states: IDLE, READ, WRITE, DONE. req_ready = (state == IDLE).
- Accept edge: on valid & ready, latch op/addr/wdata/nowr/pc and go to READ.
- Legal CSR address: one of 0x300/0x305/0x341/0x342.
- Illegal request (reserved op, or CSR op with an illegal address): IDLE -> DONE directly. rsp_illegal=1, rsp_rdata=0, no csr_wen, no redirect.
- READ, csr_raddr by op:
  - CSR op: latched addr
  - ECALL: 0x305
  - MRET: 0x341
  - csr_rdata is captured into old_q.
- READ next state: MRET -> DONE; all other ops -> WRITE.
- WRITE (csr_wen=1 for exactly one cycle, unless suppressed):
  - CSRRW: new = wdata. Never suppressed (req_nowr ignored).
  - CSRRS: new = old_q | wdata.
  - CSRRC: new = old_q & ~wdata.
  - CSRRS/CSRRC with nowr=1: csr_wen=0, state still passes through WRITE.
  - CSR ops drive both ports to the same addr/data, so the second port never hits a stray register.
  - ECALL: port1 = 0x341 <- req_pc, port2 = 0x342 <- MCAUSE_ECALL.
  - WRITE -> DONE.
- DONE:
  - rsp_valid = 1. rsp_rdata = old_q for CSR ops, else 0.
  - ECALL/MRET: redirect_valid = 1, redirect_pc = {old_q[31:2], 2'b00} (mtvec direct mode only; mepc alignment forced).
  - DONE -> IDLE. A new request is accepted no earlier than the cycle after DONE.
- Latency from the accept edge T:
  - CSR ops/ECALL: rsp at T+3.
  - MRET: rsp at T+2.
  - Illegal: rsp at T+1.
- mstatus is never modified by ECALL/MRET (MIE/MPIE stacking out of scope).
- Idle outputs: csr_wen=0, csr_raddr=0x300, waddr1=waddr2=0x300, wdata1=wdata2=0. Ports are don't-care when wen=0 but are driven to these constants.
- Reset (rst=0 at a clock edge, any state):
  - State -> IDLE; all latches and old_q cleared.
  - rsp_valid = redirect_valid = rsp_illegal = csr_wen = 0 from the following cycle.
  - An in-flight op is dropped with no write. The CSR file's own reset is separate.
- req_valid outside IDLE is ignored; the requester must hold it until accepted.

Test Plan:
- CSRRW 0x305, wdata 0x8000_0100, mtvec previously 0x0 -> wen=1 at T+2 on both ports (0x305, 0x8000_0100); at T+3 rsp_valid=1, rsp_rdata=0x0, no redirect.
- CSRRS 0x300 wdata 0x8 with mstatus 0x1800 -> write 0x1808, rsp_rdata=0x1800. Repeat with nowr=1 -> csr_wen stays 0, rsp_rdata=0x1808.
- ECALL pc 0x8000_0040, mtvec 0x8000_0103 -> at T+2 mepc<-0x8000_0040 and mcause<-11; at T+3 redirect_valid=1, redirect_pc=0x8000_0100.
- MRET with mepc 0x8000_0044 -> rsp and redirect at T+2, redirect_pc=0x8000_0044, csr_wen never asserted.
- CSRRW 0x7C0 and op 011 -> rsp_valid=rsp_illegal=1 at T+1, rsp_rdata=0, no wen.
- Back-to-back requests held valid: second accepted only in the cycle after DONE. rst=0 asserted in WRITE of an ECALL -> no wen in the following cycle, req_ready=1 after release, no rsp/redirect pulse.
